// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// Synchronises the raw rx pin and detects a start edge. Each bit is sampled
// at its nominal centre, and every good byte is presented on data_out with a
// one-cycle data_valid strobe.
// Optional feature macro: UART_RX_FERR_EN adds the frame_err port. With it, a
// bad stop bit pulses frame_err and exposes the bad byte on data_out.
// TICKS_PER_BIT (CLOCK_FREQ / BAUD_RATE) must be at least 4.
module uart_rx #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy
`ifdef UART_RX_FERR_EN
  ,
  output logic       frame_err
`endif
);

  localparam int unsigned TICKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT      = TICKS_PER_BIT / 2;
  localparam int unsigned TICK_W        = 32;
  localparam int unsigned BIT_W         = 3;
  localparam int unsigned DATA_W        = 8;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q,  tick_d;
  logic [BIT_W-1:0]    bit_q,   bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
`ifdef UART_RX_FERR_EN
  logic                ferr_q,  ferr_d;
`endif

  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_prev_q;

  // Two-flop synchroniser plus one-cycle history for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef UART_RX_FERR_EN
      ferr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
`ifdef UART_RX_FERR_EN
      ferr_q  <= ferr_d;
`endif
    end
  end

  // Next-state, bit-centre sampling and strobe generation.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
`ifdef UART_RX_FERR_EN
    ferr_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a falling edge starts a frame; a line held low is ignored.
        if (rx_prev_q && !rx_s2_q) begin
          state_d = ST_START;
          tick_d  = '0;
        end
      end

      ST_START: begin
        if (tick_q == TICK_MID) begin
          if (!rx_s2_q) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_d = ST_IDLE;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_DATA: begin
        if (tick_q == TICK_LAST) begin
          shift_d = {rx_s2_q, shift_q[DATA_W-1:1]};
          tick_d  = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (tick_q == TICK_LAST) begin
          state_d = ST_IDLE;
          if (rx_s2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
`ifdef UART_RX_FERR_EN
            data_d = shift_q;
            ferr_d = 1'b1;
`endif
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q != ST_IDLE);
`ifdef UART_RX_FERR_EN
  assign frame_err  = ferr_q;
`endif

endmodule
